step_sequencer: RTL and testbench

Front-end timing stage of the 10-bit processor. It debounces the board's "Enter" pushbutton into single-cycle step pulses, owns the 2-bit timestep counter `T`, and owns the instruction register `INST`. Both `T` and `INST` feed the combinational controller. The controller's `Clr` and `IRin` outputs come back to this block and decide how `T` and `INST` advance on each step.

---
 rtl/step_sequencer.sv | 58 +++++
 tb/tb_step_sequencer.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/step_sequencer.sv
// Front-end timing stage: debounces the Enter button into single-cycle Step
// pulses and owns the timestep counter T and the instruction register INST.
module step_sequencer #(
  parameter int unsigned DEBOUNCE_CYCLES = 250000
) (
  input  logic       Clock,
  input  logic       Reset,
  input  logic       Enter,
  input  logic       Clr,
  input  logic       IRin,
  input  logic [9:0] Data,
  output logic [1:0] T,
  output logic [9:0] INST,
  output logic       Step
);

  localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             s1;
  logic             s2;
  logic             deb;
  logic [CNT_W-1:0] cnt;

  always_ff @(posedge Clock) begin
    if (Reset) begin
      s1   <= 1'b0;
      s2   <= 1'b0;
      deb  <= 1'b0;
      cnt  <= '0;
      Step <= 1'b0;
      T    <= 2'd0;
      INST <= 10'd0;
    end else begin
      s1   <= Enter;
      s2   <= s1;
      Step <= 1'b0;

      // Accept a new level only after it has differed from deb for the full window
      if (s2 == deb) begin
        cnt <= '0;
      end else if (cnt == CNT_LAST) begin
        deb  <= s2;
        cnt  <= '0;
        Step <= s2;
      end else begin
        cnt <= cnt + CNT_W'(1);
      end

      // T/INST still show pre-step values during the Step cycle; commit at its closing edge
      if (Step) begin
        T <= Clr ? 2'd0 : T + 2'd1;
        if (IRin) INST <= Data;
      end
    end
  end

endmodule

// File: tb/tb_step_sequencer.sv
// Self-checking bench for step_sequencer with DEBOUNCE_CYCLES=4: vector table
// for reset/clean press/release, then directed multi-cycle sequences.
module tb_step_sequencer;

  logic       Clock;
  logic       Reset;
  logic       Enter;
  logic       Clr;
  logic       IRin;
  logic [9:0] Data;
  logic [1:0] T;
  logic [9:0] INST;
  logic       Step;

  int total;
  int bad;

  logic [1:0] exp_t;
  logic [9:0] exp_inst;

  typedef struct {
    logic       rst;
    logic       en;
    logic       clr;
    logic       irin;
    logic [9:0] data;
    logic [1:0] t;
    logic [9:0] inst;
    logic       step;
  } vec_t;

  vec_t vecs[$];

  step_sequencer #(.DEBOUNCE_CYCLES(4)) dut (
    .Clock (Clock),
    .Reset (Reset),
    .Enter (Enter),
    .Clr   (Clr),
    .IRin  (IRin),
    .Data  (Data),
    .T     (T),
    .INST  (INST),
    .Step  (Step)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  task automatic tick();
    @(posedge Clock);
    #1;
  endtask

  task automatic check(input string name, input logic [9:0] act, input logic [9:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic add_vec(input logic rst, input logic en, input logic clr, input logic irin,
                         input logic [9:0] data, input logic [1:0] t, input logic [9:0] inst,
                         input logic step, input int reps);
    vec_t v;
    v.rst = rst; v.en = en; v.clr = clr; v.irin = irin; v.data = data;
    v.t = t; v.inst = inst; v.step = step;
    for (int i = 0; i < reps; i++) vecs.push_back(v);
  endtask

  // One full press/release; expects Step exactly 6 edges after the press.
  task automatic do_step(input logic c, input logic ir, input logic [9:0] d);
    Clr = c; IRin = ir; Data = d; Enter = 1'b1;
    for (int i = 1; i <= 6; i++) begin
      tick();
      check("step_latency", 10'(Step), (i == 6) ? 10'd1 : 10'd0);
    end
    check("t_hold_in_step", 10'(T), 10'(exp_t));
    check("inst_hold_in_step", INST, exp_inst);
    tick();
    exp_t = c ? 2'd0 : exp_t + 2'd1;
    if (ir) exp_inst = d;
    check("t_after_step", 10'(T), 10'(exp_t));
    check("inst_after_step", INST, exp_inst);
    check("step_falls", 10'(Step), 10'd0);
    Enter = 1'b0; Clr = 1'b0; IRin = 1'b0;
    for (int i = 0; i < 8; i++) begin
      tick();
      check("no_step_release", 10'(Step), 10'd0);
    end
  endtask

  initial begin
    total = 0;
    bad = 0;
    Reset = 1'b1; Enter = 1'b1; Clr = 1'b0; IRin = 1'b1; Data = 10'h3FF;

    // Reset with button held, then clean press latching 10'b0001100010, then release
    add_vec(1, 1, 0, 1, 10'h3FF, 2'd0, 10'h000, 1'b0, 2);
    add_vec(0, 1, 0, 1, 10'h062, 2'd0, 10'h000, 1'b0, 5);
    add_vec(0, 1, 0, 1, 10'h062, 2'd0, 10'h000, 1'b1, 1);
    add_vec(0, 1, 0, 1, 10'h062, 2'd1, 10'h062, 1'b0, 2);
    add_vec(0, 0, 1, 1, 10'h3FF, 2'd1, 10'h062, 1'b0, 7);

    foreach (vecs[i]) begin
      Reset = vecs[i].rst; Enter = vecs[i].en; Clr = vecs[i].clr;
      IRin = vecs[i].irin; Data = vecs[i].data;
      tick();
      check($sformatf("vec%0d_T", i), 10'(T), 10'(vecs[i].t));
      check($sformatf("vec%0d_INST", i), INST, vecs[i].inst);
      check($sformatf("vec%0d_Step", i), 10'(Step), 10'(vecs[i].step));
    end
    exp_t = 2'd1;
    exp_inst = 10'h062;

    // Bounce: 1,0,1,0 for two cycles each, then hold high
    Clr = 1'b0; IRin = 1'b0; Data = 10'h000;
    for (int i = 0; i < 8; i++) begin
      Enter = ((i / 2) % 2 == 0) ? 1'b1 : 1'b0;
      tick();
      check("bounce_no_step", 10'(Step), 10'd0);
    end
    Enter = 1'b1;
    for (int i = 1; i <= 6; i++) begin
      tick();
      check("bounce_final_step", 10'(Step), (i == 6) ? 10'd1 : 10'd0);
    end
    tick();
    exp_t = exp_t + 2'd1;
    check("bounce_t", 10'(T), 10'(exp_t));
    for (int i = 0; i < 4; i++) begin
      tick();
      check("held_no_retrigger", 10'(Step), 10'd0);
    end
    Enter = 1'b0;
    for (int i = 0; i < 12; i++) begin
      tick();
      check("bounce_release_no_step", 10'(Step), 10'd0);
    end

    // Clear to 0, then wrap 1,2,3,0, then clear from T=2
    do_step(1'b1, 1'b0, 10'h000);
    check("clr_to_zero", 10'(T), 10'd0);
    for (int i = 1; i <= 4; i++) begin
      do_step(1'b0, 1'b0, 10'h000);
      check("wrap_seq", 10'(T), 10'(i % 4));
    end
    do_step(1'b0, 1'b0, 10'h000);
    do_step(1'b0, 1'b0, 10'h000);
    check("at_t2", 10'(T), 10'd2);
    do_step(1'b1, 1'b0, 10'h000);
    check("clr_from_t2", 10'(T), 10'd0);

    // Simultaneous Clr+IRin at T=3
    for (int i = 0; i < 3; i++) do_step(1'b0, 1'b0, 10'h000);
    check("at_t3", 10'(T), 10'd3);
    do_step(1'b1, 1'b1, 10'h2AB);
    check("simul_t", 10'(T), 10'd0);
    check("simul_inst", INST, 10'h2AB);

    // Clr/IRin pulsed without a step
    Clr = 1'b1; IRin = 1'b1; Data = 10'h155;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("idle_t", 10'(T), 10'd0);
      check("idle_inst", INST, 10'h2AB);
    end
    Clr = 1'b0; IRin = 1'b0;

    // Reset during the Step cycle at T=2
    do_step(1'b0, 1'b0, 10'h000);
    do_step(1'b0, 1'b0, 10'h000);
    check("pre_reset_t2", 10'(T), 10'd2);
    IRin = 1'b1; Data = 10'h155; Enter = 1'b1;
    for (int i = 1; i <= 6; i++) begin
      tick();
      check("mid_step_latency", 10'(Step), (i == 6) ? 10'd1 : 10'd0);
    end
    Reset = 1'b1; Enter = 1'b0;
    tick();
    check("mid_reset_t", 10'(T), 10'd0);
    check("mid_reset_inst", INST, 10'h000);
    check("mid_reset_step", 10'(Step), 10'd0);
    Reset = 1'b0; IRin = 1'b0;
    for (int i = 0; i < 12; i++) begin
      tick();
      check("post_reset_no_step", 10'(Step), 10'd0);
      check("post_reset_t", 10'(T), 10'd0);
    end
    exp_t = 2'd0;
    exp_inst = 10'h000;
    do_step(1'b0, 1'b1, 10'h155);
    check("repress_t", 10'(T), 10'd1);
    check("repress_inst", INST, 10'h155);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
